repsub_divider: RTL and testbench

Unsigned integer divider built as a controller FSM plus a repeated-subtraction datapath. It is the inverse of the team's repeated-addition multiplier and uses the same operand-loading style: the dividend and then the divisor arrive on one shared `data_in` bus on consecutive cycles while `start` is held high. It produces the quotient and remainder, with a one-cycle `done` pulse. It sits beside the multiplier as an arithmetic unit driven by a sequencing master.

---
 rtl/repsub_div_pkg.sv | 16 +
 rtl/repsub_div_datapath.sv | 32 +++
 rtl/repsub_divider.sv | 66 ++++++
 tb/tb_repsub_divider.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/repsub_div_pkg.sv
// repsub_div_pkg: state encoding and control strobes for the repeated-subtraction divider
package repsub_div_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD_DVS = 2'd1, SUB = 2'd2, DONE = 2'd3} state_t;
  typedef struct packed {
    logic ld_r;
    logic ld_b;
    logic clr_q;
    logic sub_en;
    logic set_q_ones;
  } strobe_t;
  localparam strobe_t STB_NONE     = '0;
  localparam strobe_t STB_LOAD_A   = '{ld_r: 1'b1, ld_b: 1'b0, clr_q: 1'b1, sub_en: 1'b0, set_q_ones: 1'b0};
  localparam strobe_t STB_LOAD_B   = '{ld_r: 1'b0, ld_b: 1'b1, clr_q: 1'b0, sub_en: 1'b0, set_q_ones: 1'b0};
  localparam strobe_t STB_ZERO_DVS = '{ld_r: 1'b0, ld_b: 1'b1, clr_q: 1'b0, sub_en: 1'b0, set_q_ones: 1'b1};
  localparam strobe_t STB_SUB      = '{ld_r: 1'b0, ld_b: 1'b0, clr_q: 1'b0, sub_en: 1'b1, set_q_ones: 1'b0};
endpackage

// File: rtl/repsub_div_datapath.sv
// repsub_div_datapath: R/B/Q registers, unsigned compare and subtractor
module repsub_div_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ld_r,
  input  logic             ld_b,
  input  logic             clr_q,
  input  logic             sub_en,
  input  logic             set_q_ones,
  output logic             r_ge_b,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  logic [WIDTH-1:0] b;
  assign r_ge_b = remainder >= b;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      remainder <= '0;
      b         <= '0;
      quotient  <= '0;
    end else begin
      if (ld_r) remainder <= data_in;
      else if (sub_en) remainder <= remainder - b;
      if (ld_b) b <= data_in;
      if (clr_q) quotient <= '0;
      else if (set_q_ones) quotient <= '1;
      else if (sub_en) quotient <= quotient + WIDTH'(1);
    end
endmodule

// File: rtl/repsub_divider.sv
// repsub_divider: controller FSM over a repeated-subtraction datapath; REPSUB_DIV_BYZERO_FLAG_EN adds div_by_zero
module repsub_divider
  import repsub_div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef REPSUB_DIV_BYZERO_FLAG_EN
  ,
  output logic             div_by_zero
`endif
);
  state_t  state, next;
  strobe_t stb;
  logic    r_ge_b;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    stb  = STB_NONE;
    case (state)
      IDLE: if (start) begin
        stb  = STB_LOAD_A;
        next = LOAD_DVS;
      end
      LOAD_DVS: begin
        stb  = !start ? STB_NONE : data_in == '0 ? STB_ZERO_DVS : STB_LOAD_B;
        next = !start ? IDLE : data_in == '0 ? DONE : SUB;
      end
      SUB: begin
        stb  = start && r_ge_b ? STB_SUB : STB_NONE;
        next = !start ? IDLE : r_ge_b ? SUB : DONE;
      end
      default: next = IDLE;
    endcase
  end
  assign busy = state == LOAD_DVS || state == SUB;
  assign done = state == DONE;
`ifdef REPSUB_DIV_BYZERO_FLAG_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) div_by_zero <= 1'b0;
    else if (stb.ld_r) div_by_zero <= 1'b0;
    else if (stb.set_q_ones) div_by_zero <= 1'b1;
`endif
  repsub_div_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .ld_r       (stb.ld_r),
    .ld_b       (stb.ld_b),
    .clr_q      (stb.clr_q),
    .sub_en     (stb.sub_en),
    .set_q_ones (stb.set_q_ones),
    .r_ge_b     (r_ge_b),
    .quotient   (quotient),
    .remainder  (remainder)
  );
endmodule

// File: tb/tb_repsub_divider.sv
// tb_repsub_divider: directed vectors with a queued scoreboard checked by a done monitor
module tb_repsub_divider;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data_in = '0;
  logic       busy, done;
  logic [7:0] quotient, remainder;
  logic       dbz;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
  } exp_t;
  exp_t sb[$];

  repsub_divider #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .data_in   (data_in),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef REPSUB_DIV_BYZERO_FLAG_EN
    ,
    .div_by_zero (dbz)
`endif
  );
`ifndef REPSUB_DIV_BYZERO_FLAG_EN
  assign dbz = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) if (done) begin
    chk("busy_with_done", int'(busy), 0);
    if (sb.size() == 0) chk("unexpected_done", 1, 0);
    else begin
      exp_t e;
      e = sb.pop_front();
      chk("quotient", int'(quotient), int'(e.q));
      chk("remainder", int'(remainder), int'(e.r));
`ifdef REPSUB_DIV_BYZERO_FLAG_EN
      chk("div_by_zero", int'(dbz), int'(e.z));
`endif
    end
  end

  // Drives one operation; lat is the edge (counting the dividend load as 1) after which done must be seen.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] q,
                        input logic [7:0] r, input int lat);
    int n;
    @(negedge clk);
    start = 1'b1;
    data_in = a;
    @(negedge clk);
    n = 1;
    data_in = b;
    sb.push_back('{q: q, r: r, z: (b == 0)});
    chk("busy_after_load", int'(busy), 1);
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
      if (!done) chk("busy_running", int'(busy), 1);
    end
    chk("done_latency", n, lat);
    start = 1'b0;
    @(negedge clk);
    chk("busy_idle", int'(busy), 0);
    chk("done_pulse_width", int'(done), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_q", int'(quotient), 0);
    chk("reset_r", int'(remainder), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    reset = 1'b0;
    run_op(8'd23, 8'd5, 8'd4, 8'd3, 7);
    run_op(8'd200, 8'd1, 8'd200, 8'd0, 203);
    run_op(8'd3, 8'd9, 8'd0, 8'd3, 3);
    run_op(8'd0, 8'd7, 8'd0, 8'd0, 3);
    run_op(8'd42, 8'd0, 8'hFF, 8'd42, 2);
`ifdef REPSUB_DIV_BYZERO_FLAG_EN
    chk("dbz_held_idle", int'(dbz), 1);
`endif
    chk("held_q_after_done", int'(quotient), 255);
    chk("held_r_after_done", int'(remainder), 42);
    // Abort: dividend 100, divisor 3, start dropped after edge 10 (8 subtractions done).
    @(negedge clk);
    start = 1'b1;
    data_in = 8'd100;
    @(negedge clk);
    data_in = 8'd3;
`ifdef REPSUB_DIV_BYZERO_FLAG_EN
    chk("dbz_cleared_on_load", int'(dbz), 0);
`endif
    repeat (9) @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_q", int'(quotient), 8);
    chk("abort_r", int'(remainder), 76);
    run_op(8'd9, 8'd3, 8'd3, 8'd0, 6);
    // Reset in the middle of a long SUB phase.
    @(negedge clk);
    start = 1'b1;
    data_in = 8'd200;
    @(negedge clk);
    data_in = 8'd1;
    repeat (20) @(negedge clk);
    chk("pre_reset_busy", int'(busy), 1);
    reset = 1'b1;
    #1;
    chk("midreset_q", int'(quotient), 0);
    chk("midreset_r", int'(remainder), 0);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_done", int'(done), 0);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    run_op(8'd17, 8'd4, 8'd4, 8'd1, 7);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
